// File: rtl/pcie.sv
// pcie: byte FIFO with INIT/IDLE/ACTIVE/ERROR link state machine.
// Ports: CLK, RESET (async), reset (sync re-init), CONTROL, DATA, DATA_out.
// CONTROL[0]=WR push, CONTROL[1]=RD pop, CONTROL[3:2]=output transform.
// DATA_out is the registered, transformed byte of the last accepted pop.
// Macro PCIE_SCRAMBLE_EN: mode 11 XORs with 8'h55 (else pass-through).
module pcie #(
    parameter int DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       reset,
    input  logic [3:0] CONTROL,
    input  logic [7:0] DATA,
    output logic [7:0] DATA_out
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        ACTIVE,
        ERROR
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    init_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic [7:0]    mem [DEPTH];

    logic       wr;
    logic       rd;
    logic [1:0] mode;
    logic       go;
    logic       empty;
    logic       full;
    logic       underflow;
    logic       overflow;
    logic       do_push;
    logic       do_pop;

    assign wr   = CONTROL[0];
    assign rd   = CONTROL[1];
    assign mode = CONTROL[3:2];

    // Commands are only honoured in IDLE/ACTIVE and lose to a sync reset.
    assign go        = ((state == IDLE) || (state == ACTIVE)) && !reset;
    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    // An empty-FIFO read is an error even when a write arrives with it.
    assign underflow = go && rd && empty;
    assign overflow  = go && wr && !rd && full;
    assign do_pop    = go && rd && !empty;
    assign do_push   = go && wr && !underflow && (!full || rd);

    assign count_nxt = count
                     + {{AW{1'b0}}, do_push}
                     - {{AW{1'b0}}, do_pop};

    function automatic logic [7:0] xform(input logic [1:0] m,
                                         input logic [7:0] d);
        logic [7:0] r;
        r = d;
        unique case (m)
            2'b01: r = ~d;
            2'b10: r = {d[3:0], d[7:4]};
`ifdef PCIE_SCRAMBLE_EN
            2'b11: r = d ^ 8'h55;
`else
            2'b11: r = d;
`endif
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        state_nxt = state;
        unique case (state)
            INIT: begin
                if (init_cnt == 2'd3) state_nxt = IDLE;
            end
            IDLE, ACTIVE: begin
                if (underflow || overflow) state_nxt = ERROR;
                else if (count_nxt == '0)  state_nxt = IDLE;
                else                       state_nxt = ACTIVE;
            end
            ERROR: state_nxt = ERROR;
            default: state_nxt = INIT;
        endcase
        if (reset) state_nxt = INIT;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= INIT;
            init_cnt <= 2'd0;
        end else begin
            state <= state_nxt;
            if (reset || (state != INIT)) init_cnt <= 2'd0;
            else                          init_cnt <= init_cnt + 2'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            DATA_out <= 8'h00;
        end else if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            DATA_out <= 8'h00;
        end else begin
            count <= count_nxt;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                DATA_out <= xform(mode, mem[rd_ptr]);
            end
            // Errors never coincide with a pop, so clearing here is safe.
            if (underflow || overflow) DATA_out <= 8'h00;
        end
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= DATA;
    end

endmodule

// File: tb/tb_pcie.sv
// tb_pcie: directed self-checking bench for pcie.
// Checks reset, INIT length, FIFO order, transforms and error handling.
module tb_pcie;

    logic       CLK;
    logic       RESET;
    logic       reset;
    logic [3:0] CONTROL;
    logic [7:0] DATA;
    logic [7:0] DATA_out;

    int checks = 0;
    int fails  = 0;

    localparam logic [3:0] NOP = 4'b0000;
    localparam logic [3:0] WR  = 4'b0001;
    localparam logic [3:0] RD  = 4'b0010;
    localparam logic [3:0] WRD = 4'b0011;

`ifdef PCIE_SCRAMBLE_EN
    localparam logic [7:0] M11_3C = 8'h69;
`else
    localparam logic [7:0] M11_3C = 8'h3C;
`endif

    pcie #(.DEPTH(4)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .reset    (reset),
        .CONTROL  (CONTROL),
        .DATA     (DATA),
        .DATA_out (DATA_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, pass the edge, settle 1 time unit.
    task automatic cyc(input logic [3:0] c, input logic [7:0] d);
        CONTROL = c;
        DATA    = d;
        @(posedge CLK);
        #1;
        CONTROL = NOP;
    endtask

    // Writes during the 4 INIT cycles must all be dropped.
    task automatic init_wr;
        for (int i = 0; i < 4; i++) cyc(WR, 8'h11);
    endtask

    task automatic sync_rst;
        reset = 1'b1;
        cyc(WR, 8'h11);
        reset = 1'b0;
        chk("sync_rst", DATA_out, 8'h00);
        init_wr();
    endtask

    initial begin
        RESET   = 1'b1;
        reset   = 1'b0;
        CONTROL = NOP;
        DATA    = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out", DATA_out, 8'h00);
        RESET = 1'b0;

        init_wr();
        cyc(WR, 8'hA5);
        cyc(RD, 8'h00);
        chk("first_a5", DATA_out, 8'hA5);
        cyc(NOP, 8'h00);
        chk("hold", DATA_out, 8'hA5);

        // Async reset mid-cycle, then the same INIT behaviour again.
        #3 RESET = 1'b1;
        #1 chk("async_rst", DATA_out, 8'h00);
        @(posedge CLK);
        #1 RESET = 1'b0;
        init_wr();
        cyc(WR, 8'hA5);
        cyc(RD, 8'h00);
        chk("post_rst_a5", DATA_out, 8'hA5);

        // In-order pops across pointer wrap.
        cyc(WR, 8'h12);
        cyc(WR, 8'h34);
        cyc(WR, 8'h56);
        cyc(WR, 8'h78);
        cyc(RD, 8'h00);
        chk("pop0", DATA_out, 8'h12);
        cyc(RD, 8'h00);
        chk("pop1", DATA_out, 8'h34);
        cyc(RD, 8'h00);
        chk("pop2", DATA_out, 8'h56);
        cyc(RD, 8'h00);
        chk("pop3", DATA_out, 8'h78);
        cyc(RD, 8'h00);
        chk("idle_uf", DATA_out, 8'h00);
        cyc(WR, 8'h44);
        cyc(RD, 8'h00);
        chk("err_ign", DATA_out, 8'h00);

        // Transform modes.
        sync_rst();
        for (int i = 0; i < 4; i++) cyc(WR, 8'h3C);
        cyc({2'b01, RD[1:0]}, 8'h00);
        chk("mode01", DATA_out, 8'hC3);
        cyc({2'b10, RD[1:0]}, 8'h00);
        chk("mode10", DATA_out, 8'hC3);
        cyc({2'b11, RD[1:0]}, 8'h00);
        chk("mode11", DATA_out, M11_3C);
        cyc({2'b11, NOP[1:0]}, 8'h00);
        chk("mode_hold", DATA_out, M11_3C);
        cyc(RD, 8'h00);
        chk("mode00", DATA_out, 8'h3C);

        // Full FIFO: WR+RD is fine, lone WR overflows.
        cyc(WR, 8'hAA);
        cyc(WR, 8'hBB);
        cyc(WR, 8'hCC);
        cyc(WR, 8'hDD);
        cyc(WRD, 8'hEE);
        chk("full_wr_rd", DATA_out, 8'hAA);
        cyc(WR, 8'hFF);
        chk("ovf", DATA_out, 8'h00);
        cyc(RD, 8'h00);
        chk("ovf_rd_ign", DATA_out, 8'h00);
        sync_rst();
        cyc(WR, 8'h42);
        cyc(RD, 8'h00);
        chk("after_ovf", DATA_out, 8'h42);

        // Underflow with simultaneous write.
        cyc(WRD, 8'h99);
        chk("uf_wr_rd", DATA_out, 8'h00);
        cyc(RD, 8'h00);
        chk("uf_rd_ign", DATA_out, 8'h00);

        // Sync reset while ACTIVE flushes queued bytes.
        sync_rst();
        cyc(WR, 8'h01);
        cyc(WR, 8'h02);
        cyc(WR, 8'h03);
        cyc(WR, 8'h04);
        cyc(RD, 8'h00);
        chk("act_pop", DATA_out, 8'h01);
        sync_rst();
        cyc(WR, 8'h77);
        cyc(RD, 8'h00);
        chk("flushed", DATA_out, 8'h77);
        cyc(RD, 8'h00);
        chk("flush_uf", DATA_out, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/pcie.md
PCIE -- requirements
Module: pcie

Interface
REQ-001 Parameter DEPTH, default 4, FIFO depth in bytes; SHALL be a power of two, at least 2.
REQ-002 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RESET  input  1  reset, asynchronous, active-high.
REQ-004 reset  input  1  synchronous link re-initialisation request, active-high.
REQ-005 CONTROL  input  4  [0]=WR push, [1]=RD pop, [3:2]=output transform mode.
REQ-006 DATA  input  8  byte pushed when WR is accepted.
REQ-007 DATA_out  output  8  registered byte from the most recent accepted pop, transformed.

Function
REQ-008 The block SHALL contain a DEPTH x 8 FIFO and a state machine with states INIT, IDLE, ACTIVE and ERROR.
REQ-009 INIT SHALL last exactly 4 cycles, then move to IDLE; WR and RD SHALL be ignored in INIT.
REQ-010 The machine SHALL be in IDLE when the FIFO is empty and in ACTIVE when it is non-empty, outside INIT and ERROR.
REQ-011 WR in IDLE or ACTIVE with the FIFO not full SHALL store DATA at the write pointer; the pointer wraps modulo DEPTH.
REQ-012 RD in ACTIVE SHALL pop the oldest byte and present it, transformed, on DATA_out in the next cycle (1-cycle latency).
REQ-013 Without an accepted pop, DATA_out SHALL hold its value.
REQ-014 WR and RD together with the FIFO full SHALL do both; occupancy stays DEPTH, no error.
REQ-015 WR without RD with the FIFO full SHALL be an overflow: byte discarded, machine to ERROR.
REQ-016 RD with the FIFO empty SHALL be an underflow, even with WR in the same cycle: no push, machine to ERROR.
REQ-017 In ERROR, WR and RD SHALL be ignored and DATA_out SHALL be 8'h00.
REQ-018 ERROR SHALL exit only via reset or RESET.
REQ-019 Transform by CONTROL[3:2], sampled in the pop cycle:
- 00: pass-through.
- 01: bitwise invert.
- 10: nibble swap ({d[3:0],d[7:4]}).
- 11: see REQ-025.
REQ-020 reset high at a clock edge SHALL flush the FIFO, clear both pointers and the count, set DATA_out to 8'h00 and enter INIT; it SHALL take priority over WR and RD in that cycle.
REQ-021 reset held high SHALL keep the machine in INIT with the cycle counter at 0.

Reset
REQ-022 RESET high SHALL immediately, independent of CLK, clear the FIFO pointers and count, set DATA_out to 8'h00 and set the machine to INIT with the counter at 0.
REQ-023 FIFO storage contents need not be cleared by RESET or reset.
REQ-024 After RESET deasserts, the 4-cycle INIT sequence (REQ-009) SHALL run before any command is accepted.

Configuration
REQ-025 Macro PCIE_SCRAMBLE_EN: when defined, transform mode 11 SHALL XOR the byte with 8'h55; when not defined, mode 11 SHALL act as pass-through (identical to 00).

Verification
REQ-026 Assert RESET mid-cycle -> DATA_out = 00 at once; WR in the first 4 cycles after release is ignored; first WR of 0xA5 after INIT is accepted; RD then gives DATA_out = A5 one cycle later.
REQ-027 Push 0x12, 0x34, 0x56, 0x78, then 4 pops in mode 00 -> outputs 12, 34, 56, 78 in order; machine returns to IDLE.
REQ-028 Pop 0x3C in modes 01 / 10 / 11 -> C3 / C3 / 69 with PCIE_SCRAMBLE_EN defined; mode 11 gives 3C without the macro.
REQ-029 Fill 4 bytes, WR+RD together -> no error; a fifth WR alone -> ERROR, DATA_out = 00, later RD ignored; pulse reset -> INIT, then IDLE after 4 cycles.
REQ-030 From IDLE, WR+RD together with DATA = 0x99 -> ERROR (underflow) and 0x99 not stored.
REQ-031 Assert reset while ACTIVE with 3 bytes queued -> FIFO empty after INIT; an RD then causes underflow.
